universal_shift_register_n: RTL and testbench

Parametrised universal shift register: WIDTH-bit register with per-cycle hold, shift-right, shift-left and parallel-load modes. It adds an autonomous burst engine that performs a programmed number of shifts in one direction and signals completion. It is the N-bit, sequenced successor to the 4-bit mux-per-bit shift register and sits between parallel datapaths and serial links in the shift-register subsystem.

---
 rtl/univ_shreg_pkg.sv | 21 ++
 rtl/univ_shreg_cell.sv | 43 ++++
 rtl/universal_shift_register_n.sv | 130 +++++++++++++
 tb/tb_universal_shift_register_n.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shreg_pkg.sv
// univ_shreg_pkg
// Shared encodings for universal_shift_register_n and its bit cell:
//   - mode select encodings (hold / shift right / shift left / parallel load)
//   - burst direction constants
//   - burst FSM state type
package univ_shreg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/univ_shreg_cell.sv
// univ_shreg_cell
// One register bit: 4:1 next-value mux plus a flop with async active-high reset.
// Ports:
//   clk, reset     clock, asynchronous active-high reset (clears the bit)
//   sel_i          MODE_* select for this edge
//   right_nb_i     value taken on a right shift (left-hand neighbour / serial in)
//   left_nb_i      value taken on a left shift (right-hand neighbour / serial in)
//   din_i          parallel load bit
//   q_o            stored bit
module univ_shreg_cell
    import univ_shreg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel_i,
    input  logic       right_nb_i,
    input  logic       left_nb_i,
    input  logic       din_i,
    output logic       q_o
);

    logic bit_q;
    logic bit_d;

    always_comb begin
        bit_d = bit_q;
        case (sel_i)
            MODE_HOLD: bit_d = bit_q;
            MODE_SHR:  bit_d = right_nb_i;
            MODE_SHL:  bit_d = left_nb_i;
            MODE_LOAD: bit_d = din_i;
            default:   bit_d = bit_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bit_q <= 1'b0;
        else       bit_q <= bit_d;
    end

    assign q_o = bit_q;

endmodule

// File: rtl/universal_shift_register_n.sv
// universal_shift_register_n
// WIDTH-bit universal shift register (hold / right / left / load) with an
// autonomous burst engine that performs burst_len shifts in one direction
// and pulses done when finished.
// Optional feature macro: UNIV_SHREG_ROTATE_EN adds the rot input, which
// turns every shift into a rotate (serial inputs ignored).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   rot               (UNIV_SHREG_ROTATE_EN only) rotate instead of shift
//   en, mode          manual operation enable and select (ignored while busy)
//   sin_r, sin_l      serial inputs for right / left shifts
//   din               parallel load data
//   start, burst_dir, burst_len   burst request, sampled only when idle
//   q, sout_r, sout_l register contents and serial outputs
//   busy, done        burst in progress / one-cycle completion pulse
module universal_shift_register_n
    import univ_shreg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
`ifdef UNIV_SHREG_ROTATE_EN
    input  logic             rot,
`endif
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             burst_dir,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] q_q;
    logic [1:0]       sel_d;
    logic             sin_r_eff;
    logic             sin_l_eff;
    logic [WIDTH-1:0] right_src;
    logic [WIDTH-1:0] left_src;

    // A start request in IDLE takes priority over manual mode, and the
    // register never moves on the start edge itself.
    always_comb begin
        sel_d = MODE_HOLD;
        if (state_q == SHIFT)
            sel_d = (dir_q == DIR_LEFT) ? MODE_SHL : MODE_SHR;
        else if (!start && en)
            sel_d = mode;
    end

`ifdef UNIV_SHREG_ROTATE_EN
    assign sin_r_eff = rot ? q_q[0]       : sin_r;
    assign sin_l_eff = rot ? q_q[WIDTH-1] : sin_l;
`else
    assign sin_r_eff = sin_r;
    assign sin_l_eff = sin_l;
`endif

    assign right_src = {sin_r_eff, q_q[WIDTH-1:1]};
    assign left_src  = {q_q[WIDTH-2:0], sin_l_eff};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        univ_shreg_cell u_cell (
            .clk        (clk),
            .reset      (reset),
            .sel_i      (sel_d),
            .right_nb_i (right_src[i]),
            .left_nb_i  (left_src[i]),
            .din_i      (din[i]),
            .q_o        (q_q[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            cnt_q   <= burst_len;
                            dir_q   <= burst_dir;
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end else begin
                            // Zero-length burst completes immediately.
                            done_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_register_n.sv
module tb_universal_shift_register_n;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          sin_r = 1'b0;
    logic          sin_l = 1'b0;
    logic [W-1:0]  din = '0;
    logic          start = 1'b0;
    logic          burst_dir = 1'b0;
    logic [CW-1:0] burst_len = '0;
`ifdef UNIV_SHREG_ROTATE_EN
    logic          rot = 1'b0;
`endif
    logic [W-1:0]  q;
    logic          sout_r, sout_l, busy, done;

    universal_shift_register_n #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef UNIV_SHREG_ROTATE_EN
        .rot       (rot),
`endif
        .en        (en),
        .mode      (mode),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .din       (din),
        .start     (start),
        .burst_dir (burst_dir),
        .burst_len (burst_len),
        .q         (q),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model: register value, shifts still owed by the burst,
    // burst direction, and whether the previous edge finished a burst.
    logic [W-1:0] m_q;
    int           m_rem;
    logic         m_dir;
    logic         m_done;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic rot_now();
`ifdef UNIV_SHREG_ROTATE_EN
        return rot;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_q    = '0;
        m_rem  = 0;
        m_dir  = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_shift(input logic left);
        logic in_bit;
        if (left) begin
            in_bit = rot_now() ? m_q[W-1] : sin_l;
            m_q = (m_q << 1) | W'(in_bit);
        end else begin
            in_bit = rot_now() ? m_q[0] : sin_r;
            m_q = (m_q >> 1) | (W'(in_bit) << (W - 1));
        end
    endtask

    task automatic model_edge();
        if (m_rem > 0) begin
            model_shift(m_dir);
            m_rem  = m_rem - 1;
            m_done = (m_rem == 0);
        end else begin
            m_done = 1'b0;
            if (start) begin
                if (burst_len == 0) m_done = 1'b1;
                else begin
                    m_rem = int'(burst_len);
                    m_dir = burst_dir;
                end
            end else if (en) begin
                case (mode)
                    2'b01: model_shift(1'b0);
                    2'b10: model_shift(1'b1);
                    2'b11: m_q = din;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        chk("q", 32'(q), 32'(m_q));
        chk("sout_r", 32'(sout_r), 32'(m_q[0]));
        chk("sout_l", 32'(sout_l), 32'(m_q[W-1]));
        chk("busy", 32'(busy), 32'(m_rem > 0));
        chk("done", 32'(done), 32'(m_done));
        chk("done_busy_overlap", 32'(busy & done), 32'd0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    int bc, dc;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_q", 32'(q), 32'h0);
        reset = 1'b0;

        // Manual load, right shift, reload, left shift
        en = 1'b1; mode = 2'b11; din = 8'hA5;
        tick();
        chk("load_a5", 32'(q), 32'hA5);
        mode = 2'b01; sin_r = 1'b1;
        tick();
        chk("shr_d2", 32'(q), 32'hD2);
        chk("shr_sout_r", 32'(sout_r), 32'h0);
        chk("shr_sout_l", 32'(sout_l), 32'h1);
        mode = 2'b11; din = 8'hA5;
        tick();
        mode = 2'b10; sin_l = 1'b0;
        tick();
        chk("shl_4a", 32'(q), 32'h4A);

        // Burst left 3 from 0x81 with a conflicting load held on the manual inputs
        mode = 2'b11; din = 8'h81;
        tick();
        start = 1'b1; burst_dir = 1'b1; burst_len = CW'(3); sin_l = 1'b0;
        din = 8'hFF;
        tick();
        chk("burst_start_q", 32'(q), 32'h81);
        bc = int'(busy); dc = int'(done);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            bc += int'(busy);
            dc += int'(done);
        end
        chk("burst_busy_cycles", 32'(bc), 32'd3);
        chk("burst_done_pulses", 32'(dc), 32'd1);
        chk("burst_q_08", 32'(q), 32'h08);
        en = 1'b0;
        tick();
        chk("burst_done_drop", 32'(done), 32'h0);

        // Zero-length burst
        en = 1'b1; mode = 2'b11; din = 8'h3C;
        tick();
        en = 1'b0; start = 1'b1; burst_len = '0;
        tick();
        start = 1'b0;
        chk("zero_len_done", 32'(done), 32'h1);
        chk("zero_len_busy", 32'(busy), 32'h0);
        chk("zero_len_q", 32'(q), 32'h3C);
        tick();

        // Reset in the middle of a right burst
        en = 1'b1; mode = 2'b11; din = 8'hFF;
        tick();
        en = 1'b0; start = 1'b1; burst_dir = 1'b0; burst_len = CW'(5); sin_r = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_burst_q", 32'(q), 32'h3F);
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        chk("mid_reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        start = 1'b1; burst_dir = 1'b0; burst_len = CW'(2); sin_r = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("post_reset_burst_q", 32'(q), 32'hC0);
        chk("post_reset_burst_done", 32'(done), 32'h1);
        sin_r = 1'b0;

`ifdef UNIV_SHREG_ROTATE_EN
        en = 1'b1; mode = 2'b11; din = 8'h81;
        tick();
        rot = 1'b1; mode = 2'b01; sin_r = 1'b0;
        tick();
        chk("rot_manual_c0", 32'(q), 32'hC0);
        mode = 2'b11; din = 8'h81;
        tick();
        en = 1'b0; start = 1'b1; burst_dir = 1'b0; burst_len = CW'(8);
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("rot_burst_q", 32'(q), 32'h81);
        chk("rot_burst_done", 32'(done), 32'h1);
        rot = 1'b0;
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            en        = 1'($urandom);
            mode      = 2'($urandom);
            sin_r     = 1'($urandom);
            sin_l     = 1'($urandom);
            din       = W'($urandom);
            start     = ($urandom_range(0, 5) == 0);
            burst_dir = 1'($urandom);
            burst_len = CW'($urandom_range(0, 11));
`ifdef UNIV_SHREG_ROTATE_EN
            rot       = 1'($urandom);
`endif
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
